// File: rtl/bsg_lfsr_pkg.sv
// Shared definitions for the bsg_lfsr generator/checker pair: default Galois tap masks and checker states.
// Tap masks are right-shifting Galois form; the MSB bit must be set so feedback reaches the top bit.
package bsg_lfsr_pkg;

    typedef enum logic {
        eHunt   = 1'b0,
        eLocked = 1'b1
    } lfsr_state_e;

    localparam logic [7:0]  lfsr_taps_8_gp  = 8'hB8;
    localparam logic [15:0] lfsr_taps_16_gp = 16'hB400;
    localparam logic [31:0] lfsr_taps_32_gp = 32'hA600_0000;

    // Widths without a tabulated mask fall back to the 32-bit mask; callers must override taps_p then.
    function automatic logic [31:0] default_taps(input int width);
        logic [31:0] taps;
        case (width)
            8:       taps = {24'h0, lfsr_taps_8_gp};
            16:      taps = {16'h0, lfsr_taps_16_gp};
            default: taps = lfsr_taps_32_gp;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/bsg_lfsr_step.sv
// Combinational Galois LFSR next-state: step(x) = (x >> 1) ^ (taps if x[0]).
// Zero latency; no flow control, pure function of x_i.
module bsg_lfsr_step #(
    parameter int                 width_p = 32,
    parameter logic [width_p-1:0] taps_p  = width_p'(32'hA600_0000)
) (
    input  logic [width_p-1:0] x_i,
    output logic [width_p-1:0] next_o
);

    assign next_o = (x_i >> 1) ^ ({width_p{x_i[0]}} & taps_p);

endmodule

// File: rtl/bsg_lfsr_checker.sv
// LFSR stream checker: seeds from received data, locks after lock_count_p correct predictions, then flags errors.
// One word per cycle while en_i is high (yumi_o = en_i); outputs registered, err_o one cycle after the bad word.
module bsg_lfsr_checker
    import bsg_lfsr_pkg::*;
#(
    parameter int                 width_p         = 32,
    parameter logic [width_p-1:0] taps_p          = width_p'(default_taps(width_p)),
    parameter int                 lock_count_p    = 4,
    parameter int                 unlock_count_p  = 4,
    parameter int                 err_cnt_width_p = 16
) (
    input  logic                       clk,
    input  logic                       reset_i,
    input  logic                       en_i,
    output logic                       yumi_o,
    input  logic [width_p-1:0]         data_i,
    input  logic                       clear_i,
    output logic                       locked_o,
    output logic                       err_o,
    output logic [err_cnt_width_p-1:0] err_count_o,
    output logic [width_p-1:0]         expected_o
);

    localparam int cnt_max_lp = (lock_count_p > unlock_count_p) ? lock_count_p : unlock_count_p;
    localparam int cnt_w_lp   = $clog2(cnt_max_lp + 1);

    lfsr_state_e                state_q, state_d;
    logic [width_p-1:0]         exp_q, exp_d;
    logic [cnt_w_lp-1:0]        run_q, run_d;
    logic [cnt_w_lp-1:0]        miss_q, miss_d;
    logic                       err_q, err_d;
    logic [err_cnt_width_p-1:0] cnt_q, cnt_d;

    logic [width_p-1:0] seed_next;
    logic [width_p-1:0] free_next;
    logic               data_zero;
    logic               data_match;

    bsg_lfsr_step #(
        .width_p (width_p),
        .taps_p  (taps_p)
    ) seed_step (
        .x_i    (data_i),
        .next_o (seed_next)
    );

    bsg_lfsr_step #(
        .width_p (width_p),
        .taps_p  (taps_p)
    ) free_step (
        .x_i    (exp_q),
        .next_o (free_next)
    );

    assign yumi_o     = en_i;
    assign data_zero  = (data_i == '0);
    assign data_match = (data_i == exp_q);

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        run_d   = run_q;
        miss_d  = miss_q;
        err_d   = 1'b0;

        if (en_i) begin
            case (state_q)
                eHunt: begin
                    // All-zero is the LFSR lock-up value, so it can never be a valid seed.
                    if (data_zero) begin
                        run_d = '0;
                    end else if ((run_q != '0) && data_match) begin
                        exp_d = seed_next;
                        if (run_q == cnt_w_lp'(lock_count_p)) begin
                            state_d = eLocked;
                            run_d   = '0;
                            miss_d  = '0;
                        end else begin
                            run_d = run_q + cnt_w_lp'(1);
                        end
                    end else begin
                        exp_d = seed_next;
                        run_d = cnt_w_lp'(1);
                    end
                end
                eLocked: begin
                    // Model free-runs from its own state so corrupted words never pollute it.
                    exp_d = free_next;
                    if (data_match) begin
                        miss_d = '0;
                    end else begin
                        err_d = 1'b1;
                        if (miss_q == cnt_w_lp'(unlock_count_p - 1)) begin
                            state_d = eHunt;
                            run_d   = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + cnt_w_lp'(1);
                        end
                    end
                end
                default: begin
                    state_d = eHunt;
                    run_d   = '0;
                    miss_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = err_d ? err_cnt_width_p'(1) : '0;
        end else if (err_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + err_cnt_width_p'(1);
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q <= eHunt;
            exp_q   <= '0;
            run_q   <= '0;
            miss_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            run_q   <= run_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign locked_o    = (state_q == eLocked);
    assign err_o       = err_q;
    assign err_count_o = cnt_q;
    assign expected_o  = exp_q;

endmodule

// File: tb/tb_bsg_lfsr_checker.sv
// Directed bench for bsg_lfsr_checker: stimulus pushes expected responses, monitors pop and compare
// on every consumed word; a second instance with a 2-bit error counter exercises saturation.
module tb_bsg_lfsr_checker;

    typedef struct packed {
        logic        err;
        logic        locked;
        logic [15:0] cnt;
        logic [31:0] pred;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, rst2;
    logic        en, en2, clr;
    logic [31:0] data, data2;
    logic        yumi, yumi2;
    logic        locked, locked2, err, err2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    logic [31:0] pred, pred2;

    exp_t sb[$];
    exp_t sb2[$];
    int   nvec = 0;
    int   nerr = 0;

    logic [31:0] g, g2;
    logic [31:0] tbl1  [5] = '{32'h0000_0001, 32'hA600_0000, 32'h5300_0000, 32'h2980_0000, 32'h14C0_0000};
    logic [31:0] pred1 [5] = '{32'hA600_0000, 32'h5300_0000, 32'h2980_0000, 32'h14C0_0000, 32'h0A60_0000};
    logic [31:0] tbl4  [5] = '{32'h5300_0000, 32'h2980_0000, 32'h14C0_0000, 32'h0A60_0000, 32'h0530_0000};
    logic [31:0] pred4 [5] = '{32'h2980_0000, 32'h14C0_0000, 32'h0A60_0000, 32'h0530_0000, 32'h0298_0000};

    always #5 clk = ~clk;

    bsg_lfsr_checker dut (
        .clk         (clk),
        .reset_i     (rst),
        .en_i        (en),
        .yumi_o      (yumi),
        .data_i      (data),
        .clear_i     (clr),
        .locked_o    (locked),
        .err_o       (err),
        .err_count_o (cnt),
        .expected_o  (pred)
    );

    bsg_lfsr_checker #(
        .err_cnt_width_p (2),
        .unlock_count_p  (8)
    ) dut2 (
        .clk         (clk),
        .reset_i     (rst2),
        .en_i        (en2),
        .yumi_o      (yumi2),
        .data_i      (data2),
        .clear_i     (1'b0),
        .locked_o    (locked2),
        .err_o       (err2),
        .err_count_o (cnt2),
        .expected_o  (pred2)
    );

    function automatic logic [31:0] step(input logic [31:0] x);
        return (x >> 1) ^ ({32{x[0]}} & 32'hA600_0000);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one consumed word into instance d and queue the response it must produce.
    task automatic send(input int d, input logic [31:0] w, input logic c, input logic e_err,
                        input logic e_lock, input logic [15:0] e_cnt, input logic [31:0] e_pred);
        exp_t e;
        e = '{err: e_err, locked: e_lock, cnt: e_cnt, pred: e_pred};
        @(negedge clk);
        if (d == 0) begin
            en = 1'b1; data = w; clr = c; sb.push_back(e);
            #1 check("yumi_tracks_en", {31'b0, yumi}, 32'd1);
        end else begin
            en2 = 1'b1; data2 = w; sb2.push_back(e);
        end
    endtask

    // Generator-driven word with optional corruption; the model prediction is always step(true word).
    task automatic gsend(input logic [31:0] flip, input logic c, input logic e_err,
                         input logic e_lock, input logic [15:0] e_cnt);
        send(0, g ^ flip, c, e_err, e_lock, e_cnt, step(g));
        g = step(g);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en = 1'b0; en2 = 1'b0; clr = 1'b0;
            #1 check("yumi_tracks_en_idle", {31'b0, yumi}, 32'd0);
        end
    endtask

    always begin : mon1
        logic took;
        exp_t e;
        @(posedge clk);
        took = yumi;
        @(negedge clk);
        if (took) begin
            if (sb.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL sb_underflow: consumed word with no expectation at %0t", $time);
            end else begin
                e = sb.pop_front();
                check("err_o",       {31'b0, err},    {31'b0, e.err});
                check("locked_o",    {31'b0, locked}, {31'b0, e.locked});
                check("err_count_o", {16'b0, cnt},    {16'b0, e.cnt});
                check("expected_o",  pred,            e.pred);
            end
        end else begin
            check("err_o_idle", {31'b0, err}, 32'd0);
        end
    end

    always begin : mon2
        logic took;
        exp_t e;
        @(posedge clk);
        took = yumi2;
        @(negedge clk);
        if (took) begin
            if (sb2.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL sb2_underflow: consumed word with no expectation at %0t", $time);
            end else begin
                e = sb2.pop_front();
                check("w2_err_o",       {31'b0, err2},    {31'b0, e.err});
                check("w2_locked_o",    {31'b0, locked2}, {31'b0, e.locked});
                check("w2_err_count_o", {30'b0, cnt2},    {16'b0, e.cnt});
                check("w2_expected_o",  pred2,            e.pred);
            end
        end else begin
            check("w2_err_o_idle", {31'b0, err2}, 32'd0);
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst = 1'b1; rst2 = 1'b1; en = 1'b0; en2 = 1'b0; clr = 1'b0; data = '0; data2 = '0;
        #12;
        check("reset_locked", {31'b0, locked}, 32'd0);
        check("reset_err",    {31'b0, err},    32'd0);
        check("reset_cnt",    {16'b0, cnt},    32'd0);
        check("reset_pred",   pred,            32'd0);
        @(negedge clk);
        rst = 1'b0; rst2 = 1'b0;

        // Lock onto the stream from seed 1: locked after 1 seed + 4 matches.
        for (int i = 0; i < 5; i++) send(0, tbl1[i], 1'b0, 1'b0, (i == 4), 16'd0, pred1[i]);
        g = pred1[4];
        for (int i = 0; i < 3000; i++) gsend(32'h0, 1'b0, 1'b0, 1'b1, 16'd0);

        // Single bit-0 flip: one pulse, model keeps running.
        gsend(32'h1, 1'b0, 1'b1, 1'b1, 16'd1);
        for (int i = 0; i < 10; i++) gsend(32'h0, 1'b0, 1'b0, 1'b1, 16'd1);

        // Clear, then four consecutive bad words force HUNT; clean stream relocks after 5 words.
        gsend(32'h0, 1'b1, 1'b0, 1'b1, 16'd0);
        for (int i = 0; i < 4; i++) gsend(32'h10, 1'b0, 1'b1, (i != 3), 16'(i + 1));
        for (int i = 0; i < 5; i++) gsend(32'h0, 1'b0, 1'b0, (i == 4), 16'd4);
        for (int i = 0; i < 3; i++) gsend(32'h0, 1'b0, 1'b0, 1'b1, 16'd4);

        // Random enable gaps never create errors; clear with a coincident error leaves count at 1.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1, 0) == 1) gsend(32'h0, 1'b0, 1'b0, 1'b1, 16'd4);
            else idle(1);
        end
        gsend(32'h8000_0000, 1'b1, 1'b1, 1'b1, 16'd1);
        gsend(32'h0, 1'b0, 1'b0, 1'b1, 16'd1);
        idle(2);

        // Zero words in HUNT never seed; lock after 0x53000000 plus four successors.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) send(0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0, 32'h0);
        for (int i = 0; i < 5; i++) send(0, tbl4[i], 1'b0, 1'b0, (i == 4), 16'd0, pred4[i]);
        g = pred4[4];
        for (int i = 0; i < 4; i++) gsend(32'h0, 1'b0, 1'b0, 1'b1, 16'd0);
        gsend(32'h4, 1'b0, 1'b1, 1'b1, 16'd1);

        // Asynchronous reset between edges while locked, then relock from the resumed stream.
        idle(1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_locked", {31'b0, locked}, 32'd0);
        check("async_rst_err",    {31'b0, err},    32'd0);
        check("async_rst_cnt",    {16'b0, cnt},    32'd0);
        check("async_rst_pred",   pred,            32'd0);
        idle(2);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) gsend(32'h0, 1'b0, 1'b0, (i == 4), 16'd0);
        for (int i = 0; i < 5; i++) gsend(32'h0, 1'b0, 1'b0, 1'b1, 16'd0);
        idle(2);

        // 2-bit counter saturates at 3 while err_o still pulses for every bad word.
        for (int i = 0; i < 5; i++) send(1, tbl1[i], 1'b0, 1'b0, (i == 4), 16'd0, pred1[i]);
        g2 = pred1[4];
        for (int i = 0; i < 5; i++) begin
            send(1, g2 ^ 32'h2, 1'b0, 1'b1, 1'b1, (i < 3) ? 16'(i + 1) : 16'd3, step(g2));
            g2 = step(g2);
        end
        send(1, g2, 1'b0, 1'b0, 1'b1, 16'd3, step(g2));
        idle(3);

        for (int i = 0; i < 20 && (sb.size() != 0 || sb2.size() != 0); i++) @(negedge clk);
        if (sb.size() != 0 || sb2.size() != 0) begin
            nvec++; nerr++;
            $display("FAIL drain: %0d/%0d expectations never matched, required 0", sb.size(), sb2.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
